scope_trace: RTL and testbench

//  Oscilloscope trace renderer between the sample source and the vga stage. Captures a

---
 rtl/scope_pkg.sv | 25 ++
 rtl/scope_bank_ram.sv | 24 ++
 rtl/scope_trace.sv | 179 +++++++++++++++++
 tb/tb_scope_trace.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and constants for the scope trace renderer: default raster size, capture FSM
// encoding, colour constants and the sample-to-row mapping.
package scope_pkg;

   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned V_VISIBLE_DEF = 480;

   typedef enum logic [1:0] {
      StArmed   = 2'd0,
      StCapture = 2'd1,
      StDone    = 2'd2
   } cap_state_e;

   localparam logic [2:0] TRACE_GRN = 3'b111;
   localparam logic [2:0] GRAT_BLU  = 3'b010;

   // Screen row of a sample as 11-bit signed; a negative row lies above the screen.
   function automatic logic signed [10:0] sample_row(input int unsigned y_base,
                                                     input int unsigned s);
      int r;
      r = int'(y_base) - int'(s);
      return r[10:0];
   endfunction

endpackage

// File: rtl/scope_bank_ram.sv
// Simple dual-port line store: one write port, one registered read port, no reset on contents.
module scope_bank_ram #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   // Bank select is the address MSB, so each bank is padded to a power of two.
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/scope_trace.sv
// Oscilloscope trace renderer: triggered sweep capture into a double-buffered line store and a
// two-stage pixel pipeline. Define SCOPE_GRATICULE_EN to add a blue 64-pixel graticule.
module scope_trace
   import scope_pkg::*;
#(
   parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
   parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
   parameter int unsigned SAMPLE_W   = 8,
   parameter int unsigned SAMPLES    = 640,
   parameter int unsigned Y_BASE     = 367,
   parameter int unsigned TRIG_LEVEL = 128,
   parameter int unsigned TIMEOUT    = 65535
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [10:0]         x,
   input  logic [9:0]          y,
   output logic [2:0]          red,
   output logic [2:0]          grn,
   output logic [2:0]          blu,
   output logic                debug
);

   localparam int unsigned PTR_W = $clog2(SAMPLES);
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   cap_state_e          state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [SAMPLE_W-1:0] prev_q;
   logic                front_q, front_d;
   logic                disp_valid_q, disp_valid_d;
   logic                debug_q, debug_d;

   logic                we;
   logic [PTR_W:0]      waddr;
   logic [PTR_W:0]      raddr;
   logic [SAMPLE_W-1:0] rdata;
   logic                trig_edge;
   logic                vblank_start;

   assign trig_edge    = (prev_q < SAMPLE_W'(TRIG_LEVEL)) && (sample >= SAMPLE_W'(TRIG_LEVEL));
   assign vblank_start = (x == 11'd0) && (y == 10'(V_VISIBLE));

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      to_cnt_d     = to_cnt_q;
      front_d      = front_q;
      disp_valid_d = disp_valid_q;
      debug_d      = debug_q;
      we           = 1'b0;
      waddr        = {~front_q, wr_ptr_q};
      unique case (state_q)
         StArmed: begin
            if (sample_valid) begin
               // Edge and timeout together still start a single sweep.
               if (trig_edge || (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
                  we       = 1'b1;
                  waddr    = {~front_q, {PTR_W{1'b0}}};
                  wr_ptr_d = PTR_W'(1);
                  to_cnt_d = '0;
                  state_d  = StCapture;
               end else begin
                  to_cnt_d = to_cnt_q + TO_W'(1);
               end
            end
         end
         StCapture: begin
            if (sample_valid) begin
               we = 1'b1;
               if (wr_ptr_q == PTR_W'(SAMPLES - 1)) begin
                  state_d = StDone;
               end else begin
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
               end
            end
         end
         StDone: begin
            // Swap only in vblank so a visible frame never mixes two sweeps.
            if (vblank_start) begin
               front_d      = ~front_q;
               disp_valid_d = 1'b1;
               debug_d      = ~debug_q;
               state_d      = StArmed;
            end
         end
         default: state_d = StArmed;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StArmed;
         wr_ptr_q     <= '0;
         to_cnt_q     <= '0;
         prev_q       <= '0;
         front_q      <= 1'b0;
         disp_valid_q <= 1'b0;
         debug_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         to_cnt_q     <= to_cnt_d;
         front_q      <= front_d;
         disp_valid_q <= disp_valid_d;
         debug_q      <= debug_d;
         if (sample_valid) begin
            prev_q <= sample;
         end
      end
   end

   assign raddr = {front_q, x[PTR_W-1:0]};

   scope_bank_ram #(
      .ADDR_W(PTR_W + 1),
      .DATA_W(SAMPLE_W)
   ) u_ram (
      .clk  (clk),
      .we   (we),
      .waddr(waddr),
      .wdata(sample),
      .raddr(raddr),
      .rdata(rdata)
   );

   // Stage 1 qualifies the pixel alongside the RAM read; stage 2 compares and registers colour.
   logic               vis_d, vis_q;
   logic [9:0]         y_q;
   logic signed [10:0] row;
   logic               lit;
   logic [2:0]         grn_q;

   assign vis_d = disp_valid_q && (x < 11'(SAMPLES)) && (x < 11'(H_VISIBLE))
                  && (y < 10'(V_VISIBLE));
   assign row   = sample_row(Y_BASE, 32'(rdata));
   assign lit   = vis_q && !row[10] && (row[9:0] == y_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         vis_q <= 1'b0;
         y_q   <= '0;
         grn_q <= '0;
      end else begin
         vis_q <= vis_d;
         y_q   <= y;
         grn_q <= lit ? TRACE_GRN : 3'b000;
      end
   end

`ifdef SCOPE_GRATICULE_EN
   logic       grat_d, grat_q;
   logic [2:0] blu_q;

   assign grat_d = vis_d && ((x[5:0] == 6'd0) || (y[5:0] == 6'd0));

   always_ff @(posedge clk) begin
      if (reset) begin
         grat_q <= 1'b0;
         blu_q  <= '0;
      end else begin
         grat_q <= grat_d;
         blu_q  <= (grat_q && !lit) ? GRAT_BLU : 3'b000;
      end
   end

   assign blu = blu_q;
`else
   assign blu = 3'b000;
`endif

   assign red   = 3'b000;
   assign grn   = grn_q;
   assign debug = debug_q;

endmodule

// File: tb/tb_scope_trace.sv
// Randomised scoreboard bench for scope_trace: a sweep/frame reference model predicts each
// pixel two clocks ahead and the debug toggle; a monitor pops and compares every cycle.
module tb_scope_trace;

   localparam int unsigned SAMPLES = 640;
   localparam int unsigned H_VIS   = 640;
   localparam int unsigned V_VIS   = 480;
   localparam int          Y_BASE  = 367;
   localparam int          TRIG    = 128;
   localparam int          TIMEOUT = 1500;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_valid = 1'b0;
   logic [7:0]  sample = '0;
   logic [10:0] x = '0;
   logic [9:0]  y = '0;
   logic [2:0]  red, grn, blu;
   logic        debug;

   scope_trace #(
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_valid(sample_valid),
      .sample      (sample),
      .x           (x),
      .y           (y),
      .red         (red),
      .grn         (grn),
      .blu         (blu),
      .debug       (debug)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
      int         px;
      int         py;
   } pix_t;

   pix_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   started = 1'b0;
   int   sidx = 0;

   // Reference model: displayed image, sweep being gathered, idle count while armed.
   int m_front[SAMPLES];
   int m_sweep[$];
   bit m_capturing;
   bit m_disp;
   bit m_debug;
   int m_prev;
   int m_idle;

   function automatic pix_t mk(input int r, input int g, input int b, input int px,
                               input int py);
      pix_t p;
      p.r = 3'(r); p.g = 3'(g); p.b = 3'(b); p.px = px; p.py = py;
      return p;
   endfunction

   function automatic pix_t expect_pix(input int px, input int py);
      bit on_trace;
      on_trace = m_disp && px < SAMPLES && py < V_VIS && (Y_BASE - m_front[px] == py);
      if (on_trace) return mk(0, 7, 0, px, py);
`ifdef SCOPE_GRATICULE_EN
      if (m_disp && px < SAMPLES && px < H_VIS && py < V_VIS && (px % 64 == 0 || py % 64 == 0))
         return mk(0, 0, 2, px, py);
`endif
      return mk(0, 0, 0, px, py);
   endfunction

   task automatic model_reset();
      m_sweep.delete();
      m_capturing = 1'b0;
      m_disp = 1'b0;
      m_debug = 1'b0;
      m_prev = 0;
      m_idle = 0;
   endtask

   task automatic model_step(input bit sv, input int s, input int px, input int py);
      bit done;
      done = (m_sweep.size() == SAMPLES);
      if (sv && !done) begin
         if (m_capturing) begin
            m_sweep.push_back(s);
         end else begin
            m_idle++;
            if ((m_prev < TRIG && s >= TRIG) || m_idle == TIMEOUT) begin
               m_capturing = 1'b1;
               m_sweep.delete();
               m_sweep.push_back(s);
               m_idle = 0;
            end
         end
      end
      if (sv) m_prev = s;
      if (done && px == 0 && py == V_VIS) begin
         for (int i = 0; i < SAMPLES; i++) m_front[i] = m_sweep[i];
         m_sweep.delete();
         m_capturing = 1'b0;
         m_disp = 1'b1;
         m_debug = ~m_debug;
      end
   endtask

   task automatic drive(input bit rst, input bit sv, input int s, input int px, input int py);
      @(negedge clk);
      reset = rst;
      sample_valid = sv;
      sample = 8'(s);
      x = 11'(px);
      y = 10'(py);
      started = 1'b1;
      if (rst) begin
         // Reset also flushes the pixel already in the pipeline.
         if (exp_q.size() > 0) begin
            pix_t last;
            last = exp_q.pop_back();
            exp_q.push_back(mk(0, 0, 0, last.px, last.py));
         end
         exp_q.push_back(mk(0, 0, 0, px, py));
         model_reset();
      end else begin
         exp_q.push_back(expect_pix(px, py));
         model_step(sv, s, px, py);
      end
   endtask

   task automatic pick_xy(input int swap_pct, output int px, output int py);
      int r;
      r = $urandom_range(0, 99);
      if (r < swap_pct) begin
         px = 0; py = V_VIS;
      end else if (r < 55) begin
         px = $urandom_range(0, SAMPLES - 1);
         py = Y_BASE - m_front[px];
         if (py < 0 || py >= V_VIS) py = $urandom_range(0, V_VIS - 1);
      end else if (r < 62) begin
         px = $urandom_range(0, SAMPLES - 1);
         py = Y_BASE - m_front[px] + (($urandom_range(0, 1) == 1) ? 1 : -1);
         if (py < 0 || py >= V_VIS) py = $urandom_range(0, V_VIS - 1);
      end else if (r < 72) begin
         px = $urandom_range(640, 799); py = $urandom_range(0, 524);
      end else if (r < 80) begin
         px = $urandom_range(0, 799); py = $urandom_range(480, 524);
      end else begin
         px = $urandom_range(0, 799); py = $urandom_range(0, 524);
      end
   endtask

   function automatic int gen_sample(input int mode, input int idx);
      case (mode)
         0:       return idx % 256;
         1:       return 50;
         3:       return ((idx / 37) % 2 == 1) ? 200 : 60;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic run(input int n, input int mode, input int swap_pct, input int valid_pct);
      for (int i = 0; i < n; i++) begin
         int px, py;
         bit sv;
         pick_xy(swap_pct, px, py);
         sv = ($urandom_range(0, 99) < valid_pct);
         drive(1'b0, sv, gen_sample(mode, sidx), px, py);
         if (sv) sidx++;
      end
   endtask

   initial begin : monitor
      pix_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            checks++;
            if (red !== e.r || grn !== e.g || blu !== e.b) begin
               errors++;
               $display("FAIL pixel x=%0d y=%0d got r=%0d g=%0d b=%0d want r=%0d g=%0d b=%0d",
                        e.px, e.py, red, grn, blu, e.r, e.g, e.b);
            end
         end
         if (started) begin
            checks++;
            if (debug !== m_debug) begin
               errors++;
               $display("FAIL debug at %0t got %0b want %0b", $time, debug, m_debug);
            end
         end
      end
   end

   initial begin : stimulus
      int guard;
      for (int i = 0; i < SAMPLES; i++) m_front[i] = 0;
      model_reset();

      repeat (3) drive(1'b1, 1'b0, 0, 0, 0);

      // Ramp from reset: trigger at 127->128, then (0,239) lit after the swap.
      sidx = 0;
      run(800, 0, 0, 100);
      drive(1'b0, 1'b1, sidx % 256, 0, V_VIS);
      sidx++;
      drive(1'b0, 1'b1, sidx % 256, 0, 239);
      sidx++;
      run(800, 0, 2, 100);

      // Constant 50 never crosses the level, so only the timeout starts sweeps.
      run(4500, 1, 2, 100);

      run(3000, 2, 3, 70);

      // Reset part way through a sweep.
      guard = 0;
      while (!(m_capturing && m_sweep.size() == 300) && guard < 5000) begin
         run(1, 3, 0, 100);
         guard++;
      end
      checks++;
      if (guard >= 5000) begin
         errors++;
         $display("FAIL midsweep_reach got guard=%0d want <5000", guard);
      end
      drive(1'b1, 1'b0, 0, 5, 5);
      run(2500, 3, 2, 80);

      // Return to an empty armed state, then a hand-built sweep with 255 at x=5.
      guard = 0;
      while (!(m_sweep.size() == 0 && !m_capturing) && guard < 5000) begin
         if (m_sweep.size() == SAMPLES) drive(1'b0, 1'b1, 0, 0, V_VIS);
         else drive(1'b0, 1'b1, 0, 3, 3);
         guard++;
      end
      checks++;
      if (guard >= 5000) begin
         errors++;
         $display("FAIL rearm_reach got guard=%0d want <5000", guard);
      end
      drive(1'b0, 1'b1, 0, 1, 1);
      drive(1'b0, 1'b1, 130, 1, 1);
      for (int k = 1; k < SAMPLES; k++) drive(1'b0, 1'b1, (k == 5) ? 255 : 10, k % 700, 200);
      drive(1'b0, 1'b0, 0, 0, V_VIS);
      drive(1'b0, 1'b0, 0, 5, 112);
      drive(1'b0, 1'b0, 0, 5, 111);
      drive(1'b0, 1'b0, 0, 6, 357);
      drive(1'b0, 1'b0, 0, 0, 237);
      drive(1'b0, 1'b0, 0, 640, 112);
      drive(1'b0, 1'b0, 0, 799, 357);
      drive(1'b0, 1'b0, 0, 5, 480);
      drive(1'b0, 1'b0, 0, 64, 10);
      drive(1'b0, 1'b0, 0, 64, 357);
      drive(1'b0, 1'b0, 0, 0, 0);
      run(500, 2, 2, 60);
      repeat (3) drive(1'b0, 1'b0, 0, 700, 500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
